// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared types and constants for the triggered ADC capture engine
package adc_capture_pkg;

  localparam int ADDR_W        = 10;
  localparam int DATA_W        = 8;
  localparam int DEPTH_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Mean of two samples; the 9-bit sum keeps the carry before the halving.
  function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W:1];
  endfunction

endpackage

// File: rtl/adc_capture_clk_div.sv
// rtl/adc_capture_clk_div.sv - free-running ADC conversion clock and once-per-sample strobe
module adc_clk_div #(
  parameter int CLK_DIV = 50
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_adc_clk,
  output logic o_stb
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_adc_clk;

  assign w_div_next = (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + DIV_W'(1);

  // adc_clk is registered from the next count so it stays low while in reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div     <= '0;
      r_adc_clk <= 1'b0;
    end else begin
      r_div     <= w_div_next;
      r_adc_clk <= (w_div_next < DIV_W'(CLK_DIV / 2));
    end
  end

  assign o_adc_clk = r_adc_clk;
  assign o_stb     = (r_div == DIV_W'(CLK_DIV - 1));

endmodule

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - level-crossing triggered single-shot ADC record writer
// Optional build macro ADC_CAPTURE_AVG_EN stores the mean of adjacent samples.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int CLK_DIV      = 50,
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int TRIG_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [3:0]        decim,
  output logic              adc_clk,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              auto_trig
);

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_cur, r_lvl, r_wr_data, w_sample;
  logic              r_slope, r_prev_valid, r_wren, r_auto;
  logic [3:0]        r_decim, r_dcnt;
  logic [31:0]       r_tcnt;
  logic [ADDR_W-1:0] r_wptr, r_wr_addr;
  logic              w_stb, w_accept, w_cross, w_timeout, w_trig, w_store, w_last_wr;

  adc_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .i_clk     (clk),
    .i_rst     (rst),
    .o_adc_clk (adc_clk),
    .o_stb     (w_stb)
  );

  // Decisions are taken on the strobe cycle, so adc_data is the new cur and r_cur the new prev.
  assign w_accept  = arm && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_cross   = r_prev_valid && (r_slope ? (r_cur > r_lvl && adc_data <= r_lvl)
                                              : (r_cur < r_lvl && adc_data >= r_lvl));
  assign w_timeout = (TRIG_TIMEOUT != 0) && (r_tcnt + 32'd1 == 32'(TRIG_TIMEOUT));
  assign w_trig    = w_stb && (r_state == ST_ARMED) && (w_cross || w_timeout);
  assign w_store   = w_trig || (w_stb && (r_state == ST_CAPTURE) && (r_dcnt == r_decim));
  assign w_last_wr = r_wren && (r_wr_addr == ADDR_W'(DEPTH - 1));

`ifdef ADC_CAPTURE_AVG_EN
  assign w_sample = (r_state == ST_ARMED && !r_prev_valid) ? adc_data : avg2(adc_data, r_cur);
`else
  assign w_sample = adc_data;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_accept)  w_state_next = ST_ARMED;
      ST_ARMED:         if (w_trig)    w_state_next = ST_CAPTURE;
      ST_CAPTURE:       if (w_last_wr) w_state_next = ST_DONE;
      default:                         w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cur        <= '0;
      r_lvl        <= '0;
      r_slope      <= 1'b0;
      r_decim      <= '0;
      r_dcnt       <= '0;
      r_prev_valid <= 1'b0;
      r_tcnt       <= '0;
      r_auto       <= 1'b0;
      r_wptr       <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wren       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wren  <= w_store;
      if (w_stb) r_cur <= adc_data;

      if (w_accept) begin
        r_lvl        <= trig_level;
        r_slope      <= trig_slope;
        r_decim      <= decim;
        r_prev_valid <= 1'b0;
        r_tcnt       <= '0;
        r_auto       <= 1'b0;
        r_wptr       <= '0;
      end else if (w_stb && r_state == ST_ARMED) begin
        r_prev_valid <= 1'b1;
        r_tcnt       <= r_tcnt + 32'd1;
        if (!w_cross && w_timeout) r_auto <= 1'b1;
      end

      if (w_trig)
        r_dcnt <= '0;
      else if (w_stb && r_state == ST_CAPTURE)
        r_dcnt <= (r_dcnt == r_decim) ? 4'd0 : r_dcnt + 4'd1;

      if (w_store) begin
        r_wr_data <= w_sample;
        r_wr_addr <= r_wptr;
        r_wptr    <= (r_wptr == ADDR_W'(DEPTH - 1)) ? '0 : r_wptr + ADDR_W'(1);
      end else if (w_last_wr) begin
        r_wr_addr <= '0;
      end
    end
  end

  assign wr_data   = r_wr_data;
  assign wr_addr   = r_wr_addr;
  assign wren      = r_wren;
  assign busy      = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  assign done      = (r_state == ST_DONE);
  assign auto_trig = r_auto;

endmodule
